// File: rtl/kernel_cache_read_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the kernel cache
// read arbiter. No ports; imported by the arbiter top and its sub-module.
package kernel_cache_read_arbiter_pkg;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_PTR_W   = 4;
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_ID_W   = 16;

  localparam logic [2:0] CACHE_ARSIZE_64B = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [REQ_ID_W-1:0]   id;
  } read_req_t;

  typedef struct packed {
    logic                found;
    logic [RR_PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of vec[n-1:0], searching upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] vec,
                                       input logic [RR_PTR_W-1:0]   ptr,
                                       input int                    n);
    rr_pick_t res;
    int       c;
    res = '0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      c = (int'(ptr) + k) % n;
      if (k < n && !res.found && vec[c]) begin
        res.found = 1'b1;
        res.idx   = RR_PTR_W'(c);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/kernel_cache_read_arbiter_arbiter_round_robin.sv
// Round-robin grant selector that owns the search pointer.
// Ports: ap_clk, areset (sync, active high), req (request vector),
//        enable (grant permitted this cycle), grant (one-hot),
//        grant_idx (index of grant), grant_valid (a grant is issued).
module arbiter_round_robin
  import kernel_cache_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               ap_clk,
  input  logic               areset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  rr_pick_t         pick;

  always_comb begin
    pick        = rr_pick(RR_MAX_REQ'(req), RR_PTR_W'(ptr), NUM_REQ);
    grant_valid = enable && pick.found;
    grant_idx   = pick.idx[IDX_W-1:0];
    grant       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && pick.idx == RR_PTR_W'(i)) grant[i] = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/kernel_cache_read_arbiter.sv
// Round-robin arbiter sharing the cache AXI4 read slave port among NUM_REQ
// engine read masters. Granted ARs are tagged with the requester index in
// ARID; R beats are routed back by RID with zero latency.
// Ports: ap_clk/areset; cache_setup_signal blocks new grants;
//        req_ar*/req_r* per-requester AR/R channels (R payload shared);
//        s_ar*/s_r* cache S0 read channel; outstanding_count in-flight
//        bursts; rid_error sticky flag for an RID naming no requester.
//
// state    | meaning
// AR_EMPTY | holding register free; may grant one requester
// AR_FULL  | request held and presented on s_ar*, waiting for s_arready
module kernel_cache_read_arbiter
  import kernel_cache_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 4,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      cache_setup_signal,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  output logic [1:0]                req_rresp,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic                      s_arvalid,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [7:0]                s_arlen,
  output logic [ID_W-1:0]           s_arid,
  output logic [2:0]                s_arsize,
  output logic [1:0]                s_arburst,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic                      s_rlast,
  input  logic [ID_W-1:0]           s_rid,
  input  logic [1:0]                s_rresp,
  output logic                      s_rready,
  output logic [CNT_W-1:0]          outstanding_count,
  output logic                      rid_error
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {AR_EMPTY, AR_FULL} ar_state_t;

  ar_state_t          state, state_nxt;
  read_req_t          held;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               can_grant;
  logic [CNT_W:0]     occupancy;
  logic               ar_hs;
  logic               r_last_hs;
  logic [IDX_W-1:0]   rid_idx;
  logic               rid_bad;

  // The held entry counts toward the limit so a grant never overshoots it.
  assign occupancy = {1'b0, outstanding_count} + (CNT_W + 1)'(state == AR_FULL);
  assign can_grant = (state == AR_EMPTY) && !cache_setup_signal &&
                     (occupancy < (CNT_W + 1)'(MAX_OUTSTANDING));

  arbiter_round_robin #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .req         (req_arvalid),
    .enable      (can_grant),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign req_arready = arb_grant;

  always_comb begin
    state_nxt = state;
    unique case (state)
      AR_EMPTY: if (arb_valid) state_nxt = AR_FULL;
      AR_FULL:  if (s_arready) state_nxt = AR_EMPTY;
      default:  state_nxt = AR_EMPTY;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= AR_EMPTY;
      held  <= '0;
    end else begin
      state <= state_nxt;
      if (arb_valid) begin
        held.addr <= REQ_ADDR_W'(req_araddr[arb_idx*ADDR_W +: ADDR_W]);
        held.len  <= req_arlen[arb_idx*8 +: 8];
        held.id   <= REQ_ID_W'(arb_idx);
      end
    end
  end

  assign s_arvalid = (state == AR_FULL);
  assign s_araddr  = held.addr[ADDR_W-1:0];
  assign s_arlen   = held.len;
  assign s_arid    = held.id[ID_W-1:0];
  assign s_arsize  = CACHE_ARSIZE_64B;
  assign s_arburst = AXI_BURST_INCR;

  assign ar_hs     = s_arvalid && s_arready;
  assign r_last_hs = s_rvalid && s_rready && s_rlast;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      outstanding_count <= '0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10:   outstanding_count <= outstanding_count + 1'b1;
        2'b01:   if (outstanding_count != '0) outstanding_count <= outstanding_count - 1'b1;
        default: outstanding_count <= outstanding_count;
      endcase
    end
  end

  // Comparing the full RID catches both nonzero upper bits and an index
  // beyond NUM_REQ; such beats are drained so the cache never stalls.
  always_comb begin
    rid_idx    = s_rid[IDX_W-1:0];
    rid_bad    = (32'(s_rid) >= 32'(NUM_REQ));
    req_rvalid = '0;
    s_rready   = rid_bad;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rid_bad && rid_idx == IDX_W'(i)) begin
        req_rvalid[i] = s_rvalid;
        s_rready      = req_rready[i];
      end
    end
  end

  assign req_rdata = s_rdata;
  assign req_rlast = s_rlast;
  assign req_rresp = s_rresp;

  always_ff @(posedge ap_clk) begin
    if (areset)                   rid_error <= 1'b0;
    else if (s_rvalid && rid_bad) rid_error <= 1'b1;
  end

endmodule

// File: tb/tb_kernel_cache_read_arbiter.sv
// Bench for kernel_cache_read_arbiter: instance a (4 requesters, limit 16)
// and instance b (3 requesters, limit 2) driven by directed sequences and a
// vector table for R routing.
module tb_kernel_cache_read_arbiter;

  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // instance a
  logic         a_setup = 0;
  logic [3:0]   a_arvalid = '0;
  logic [255:0] a_araddr = '0;
  logic [31:0]  a_arlen = '0;
  logic [3:0]   a_arready, a_rvalid;
  logic [511:0] a_rdata;
  logic         a_rlast;
  logic [1:0]   a_rresp;
  logic [3:0]   a_rready = '0;
  logic         a_s_arvalid;
  logic [63:0]  a_s_araddr;
  logic [7:0]   a_s_arlen;
  logic [3:0]   a_s_arid;
  logic [2:0]   a_s_arsize;
  logic [1:0]   a_s_arburst;
  logic         a_s_arready = 0;
  logic         a_s_rvalid = 0;
  logic [511:0] a_s_rdata = '0;
  logic         a_s_rlast = 0;
  logic [3:0]   a_s_rid = '0;
  logic [1:0]   a_s_rresp = '0;
  logic         a_s_rready;
  logic [4:0]   a_cnt;
  logic         a_rid_error;

  // instance b
  logic         b_setup = 0;
  logic [2:0]   b_arvalid = '0;
  logic [191:0] b_araddr = '0;
  logic [23:0]  b_arlen = '0;
  logic [2:0]   b_arready, b_rvalid;
  logic [511:0] b_rdata;
  logic         b_rlast;
  logic [1:0]   b_rresp;
  logic [2:0]   b_rready = '0;
  logic         b_s_arvalid;
  logic [63:0]  b_s_araddr;
  logic [7:0]   b_s_arlen;
  logic [3:0]   b_s_arid;
  logic [2:0]   b_s_arsize;
  logic [1:0]   b_s_arburst;
  logic         b_s_arready = 0;
  logic         b_s_rvalid = 0;
  logic [511:0] b_s_rdata = '0;
  logic         b_s_rlast = 0;
  logic [3:0]   b_s_rid = '0;
  logic [1:0]   b_s_rresp = '0;
  logic         b_s_rready;
  logic [1:0]   b_cnt;
  logic         b_rid_error;

  kernel_cache_read_arbiter #(
    .NUM_REQ(4), .ID_W(4), .ADDR_W(64), .DATA_W(512), .MAX_OUTSTANDING(16)
  ) dut_a (
    .ap_clk(ap_clk), .areset(areset), .cache_setup_signal(a_setup),
    .req_arvalid(a_arvalid), .req_araddr(a_araddr), .req_arlen(a_arlen),
    .req_arready(a_arready), .req_rvalid(a_rvalid), .req_rdata(a_rdata),
    .req_rlast(a_rlast), .req_rresp(a_rresp), .req_rready(a_rready),
    .s_arvalid(a_s_arvalid), .s_araddr(a_s_araddr), .s_arlen(a_s_arlen),
    .s_arid(a_s_arid), .s_arsize(a_s_arsize), .s_arburst(a_s_arburst),
    .s_arready(a_s_arready), .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata),
    .s_rlast(a_s_rlast), .s_rid(a_s_rid), .s_rresp(a_s_rresp),
    .s_rready(a_s_rready), .outstanding_count(a_cnt), .rid_error(a_rid_error)
  );

  kernel_cache_read_arbiter #(
    .NUM_REQ(3), .ID_W(4), .ADDR_W(64), .DATA_W(512), .MAX_OUTSTANDING(2)
  ) dut_b (
    .ap_clk(ap_clk), .areset(areset), .cache_setup_signal(b_setup),
    .req_arvalid(b_arvalid), .req_araddr(b_araddr), .req_arlen(b_arlen),
    .req_arready(b_arready), .req_rvalid(b_rvalid), .req_rdata(b_rdata),
    .req_rlast(b_rlast), .req_rresp(b_rresp), .req_rready(b_rready),
    .s_arvalid(b_s_arvalid), .s_araddr(b_s_araddr), .s_arlen(b_s_arlen),
    .s_arid(b_s_arid), .s_arsize(b_s_arsize), .s_arburst(b_s_arburst),
    .s_arready(b_s_arready), .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata),
    .s_rlast(b_s_rlast), .s_rid(b_s_rid), .s_rresp(b_s_rresp),
    .s_rready(b_s_rready), .outstanding_count(b_cnt), .rid_error(b_rid_error)
  );

  typedef struct {
    logic       rvalid;
    logic [3:0] rid;
    logic [3:0] rready;
    logic [1:0] rresp;
    logic [3:0] exp_rvalid;
    logic       exp_srready;
  } rvec_t;

  rvec_t vecs[6];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    logic [3:0] exp_id;
    int         beat;
    int         hs;
    logic [3:0] ids[$];
    logic       pat[5];

    vecs[0] = '{1'b1, 4'd0, 4'b0001, 2'b00, 4'b0001, 1'b1};
    vecs[1] = '{1'b1, 4'd0, 4'b1110, 2'b01, 4'b0001, 1'b0};
    vecs[2] = '{1'b1, 4'd2, 4'b0100, 2'b10, 4'b0100, 1'b1};
    vecs[3] = '{1'b1, 4'd3, 4'b0111, 2'b11, 4'b1000, 1'b0};
    vecs[4] = '{1'b0, 4'd1, 4'b0010, 2'b00, 4'b0000, 1'b1};
    vecs[5] = '{1'b1, 4'd9, 4'b0000, 2'b00, 4'b0000, 1'b1};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 4; i++) begin
      a_araddr[i*64 +: 64] = 64'h1000 * (i + 1);
      a_arlen[i*8 +: 8]    = 8'(i + 3);
    end
    for (int i = 0; i < 3; i++) b_araddr[i*64 +: 64] = 64'h2000 * (i + 1);

    // reset values
    repeat (3) tick();
    chk("rst_arvalid", a_s_arvalid, 0);
    chk("rst_arready", a_arready, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_rid_error", a_rid_error, 0);
    areset = 0;
    tick();

    // setup blocks grants
    a_setup = 1; a_arvalid = 4'b1111; a_s_arready = 1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok = ok & (a_arready == 4'b0000) & !a_s_arvalid;
    end
    chk("setup_block", 64'(ok), 1);
    a_setup = 0;
    #1;
    chk("first_grant", a_arready, 4'b0001);
    tick();
    chk("arsize", a_s_arsize, 3'b110);
    chk("arburst", a_s_arburst, 2'b01);

    // round-robin, one AR every two cycles
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      chk($sformatf("rr_arvalid_c%0d", c), a_s_arvalid, (c % 2 == 0));
      if (c % 2 == 0) begin
        exp_id = 4'((c / 2) % 4);
        chk($sformatf("rr_arid_c%0d", c), a_s_arid, exp_id);
        chk($sformatf("rr_araddr_c%0d", c), a_s_araddr, 64'h1000 * (exp_id + 1));
        chk($sformatf("rr_arlen_c%0d", c), a_s_arlen, exp_id + 3);
        if (c == 8) a_arvalid = 4'b0000;
      end else begin
        #1;
        chk($sformatf("rr_arready_c%0d", c), a_arready, 4'b0001 << (((c + 1) / 2) % 4));
      end
    end
    tick();
    chk("count_after_rr", a_cnt, 5);

    // wrap search: only req2
    a_arvalid = 4'b0100;
    #1; chk("only2_grant_a", a_arready, 4'b0100);
    tick(); chk("only2_arid_a", a_s_arid, 2);
    tick(); #1; chk("only2_grant_wrap", a_arready, 4'b0100);
    tick(); chk("only2_arid_wrap", a_s_arid, 2);
    tick(); a_arvalid = 4'b1111;
    #1; chk("ptr_at_3", a_arready, 4'b1000);
    tick(); chk("ptr3_arid", a_s_arid, 3);
    a_arvalid = 4'b0000;
    tick(); chk("count_8", a_cnt, 8);

    // setup rising while FULL keeps the held request
    a_s_arready = 0; a_arvalid = 4'b0001;
    tick(); a_setup = 1; a_arvalid = 4'b0000;
    tick(); chk("hold_under_setup_1", a_s_arvalid, 1);
    tick(); chk("hold_under_setup_2", a_s_arvalid, 1);
    chk("hold_under_setup_id", a_s_arid, 0);
    a_s_arready = 1;
    tick();
    chk("hold_released", a_s_arvalid, 0);
    chk("count_9", a_cnt, 9);
    a_setup = 0;

    // AR handshake and rlast in the same cycle
    a_arvalid = 4'b0001;
    tick(); a_arvalid = 4'b0000;
    a_s_rvalid = 1; a_s_rid = 0; a_s_rlast = 1; a_rready = 4'b0001;
    tick();
    chk("inc_dec_same_cycle", a_cnt, 9);
    a_s_rvalid = 0; a_s_rlast = 0;

    // 4-beat burst on rid 1 with rready toggling
    beat = 0;
    a_s_rvalid = 1; a_s_rid = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) chk("count_mid_burst", a_cnt, 9);
      a_rready  = {2'b00, pat[k], 1'b0};
      a_s_rlast = (beat == 3);
      a_s_rdata = 512'(beat + 100);
      #1;
      chk($sformatf("burst_srready_k%0d", k), a_s_rready, pat[k]);
      chk($sformatf("burst_rvalid_k%0d", k), a_rvalid, 4'b0010);
      chk($sformatf("burst_rdata_k%0d", k), a_rdata[63:0], beat + 100);
      if (k == 4) chk("burst_rlast", a_rlast, 1);
      if (pat[k]) beat++;
      tick();
    end
    a_s_rvalid = 0; a_s_rlast = 0;
    chk("count_after_burst", a_cnt, 8);

    // R routing table
    chk("rid_error_clear", a_rid_error, 0);
    for (int v = 0; v < 6; v++) begin
      a_s_rvalid = vecs[v].rvalid;
      a_s_rid    = vecs[v].rid;
      a_rready   = vecs[v].rready;
      a_s_rresp  = vecs[v].rresp;
      a_s_rdata  = 512'(v * 7 + 1);
      #1;
      chk($sformatf("vec%0d_rvalid", v), a_rvalid, vecs[v].exp_rvalid);
      chk($sformatf("vec%0d_srready", v), a_s_rready, vecs[v].exp_srready);
      chk($sformatf("vec%0d_rresp", v), a_rresp, vecs[v].rresp);
      tick();
    end
    a_s_rvalid = 0;
    chk("rid_error_set", a_rid_error, 1);
    tick();
    chk("rid_error_sticky", a_rid_error, 1);
    areset = 1; tick(); areset = 0;
    chk("rid_error_reset", a_rid_error, 0);
    chk("count_reset", a_cnt, 0);
    tick();

    // instance b: limit of 2 in-flight bursts
    b_arvalid = 3'b111; b_s_arready = 1; b_rready = 3'b111;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_s_arvalid) begin
        hs++;
        ids.push_back(b_s_arid);
      end
    end
    chk("b_handshakes", hs, 2);
    chk("b_id0", ids[0], 0);
    chk("b_id1", ids[1], 1);
    #1;
    chk("b_stalled", b_arready, 3'b000);
    chk("b_count_full", b_cnt, 2);
    b_s_rvalid = 1; b_s_rid = 0; b_s_rlast = 1; b_rready = 3'b001;
    #1; chk("b_rlast_ready", b_s_rready, 1);
    tick(); b_s_rvalid = 0; b_s_rlast = 0;
    #1; chk("b_third_grant", b_arready, 3'b100);
    tick(); chk("b_third_arid", b_s_arid, 2);
    b_arvalid = 3'b000;
    tick(); chk("b_count_back_2", b_cnt, 2);

    // instance b: rid 3 names no requester
    b_s_rvalid = 1; b_s_rid = 3; b_s_rlast = 1; b_rready = 3'b000;
    #1;
    chk("b_bad_srready", b_s_rready, 1);
    chk("b_bad_rvalid", b_rvalid, 3'b000);
    tick(); b_s_rvalid = 0; b_s_rlast = 0;
    chk("b_rid_error", b_rid_error, 1);
    chk("b_bad_drain_count", b_cnt, 1);
    repeat (3) tick();
    chk("b_rid_error_sticky", b_rid_error, 1);
    areset = 1; tick(); areset = 0;
    chk("b_rid_error_reset", b_rid_error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_cache_read_arbiter.md
Name: kernel_cache_read_arbiter

Overview:
- Round-robin arbiter sharing the single AXI4 read slave port of the kernel system cache (512-bit data, 64-bit address) among NUM_REQ engine read requesters.
- Tags each granted AR with the requester index in ARID, routes R beats back by RID, and bounds in-flight bursts.
- Issues no grants while the cache reports initialization (cache_setup_signal high).
- Sits between the engine read masters and the cache's S0 read channel inside the kernel top.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 4, ARID/RID width; must be >= IDX_W = $clog2(NUM_REQ)
ADDR_W, 64, address width
DATA_W, 512, data width
MAX_OUTSTANDING, 16, maximum in-flight bursts accepted by the cache

Ports:
ap_clk  in  1  clock
areset  in  1  synchronous active-high reset
cache_setup_signal  in  1  cache initializing; blocks new grants while high
req_arvalid  in  NUM_REQ  per-requester AR valid
req_araddr  in  NUM_REQ*ADDR_W  per-requester address
req_arlen  in  NUM_REQ*8  per-requester burst length
req_arready  out  NUM_REQ  per-requester AR accept
req_rvalid  out  NUM_REQ  per-requester R valid
req_rdata  out  DATA_W  shared R data (qualified by req_rvalid)
req_rlast  out  1  shared R last
req_rresp  out  2  shared R response
req_rready  in  NUM_REQ  per-requester R ready
s_arvalid  out  1  to cache
s_araddr  out  ADDR_W  to cache
s_arlen  out  8  to cache
s_arid  out  ID_W  to cache; {zeros, granted index}
s_arsize  out  3  constant 3'b110
s_arburst  out  2  constant 2'b01 (INCR)
s_arready  in  1  from cache
s_rvalid  in  1  from cache
s_rdata  in  DATA_W  from cache
s_rlast  in  1  from cache
s_rid  in  ID_W  from cache
s_rresp  in  2  from cache
s_rready  out  1  to cache
outstanding_count  out  $clog2(MAX_OUTSTANDING+1)  in-flight bursts
rid_error  out  1  sticky: RID index >= NUM_REQ

Behaviour:
- Reset (sync, areset high at posedge):
  - s_arvalid=0, req_arready=0, outstanding_count=0, rid_error=0.
  - Round-robin pointer=0; AR holding register cleared.
  - In-flight bursts are abandoned; requesters are reset by the same signal.
- AR holding register, one entry, states EMPTY/FULL:
  - EMPTY: can_grant = !cache_setup_signal && (outstanding_count + FULL < MAX_OUTSTANDING).
  - If can_grant and any req_arvalid: grant the first set bit searching from pointer upward with wrap; req_arready[g]=1 combinationally that cycle only.
  - On grant: latch addr/len/id=g; next state FULL; pointer <= (g+1) mod NUM_REQ.
  - FULL: s_arvalid=1 and fields stable. On s_arvalid&&s_arready, go EMPTY and increment outstanding_count.
  - No grant is issued in the handshake cycle (one AR per 2 cycles maximum).
  - Requester-to-cache AR latency is 1 cycle.
- cache_setup_signal rising while FULL: the held request remains presented; only new grants are blocked.
- Outstanding accounting:
  - +1 on downstream AR handshake; -1 on s_rvalid&&s_rready&&s_rlast.
  - Both in the same cycle: value unchanged.
  - Never exceeds MAX_OUTSTANDING (grant gating counts the FULL entry).
- R routing, combinational, zero latency:
  - idx = s_rid[IDX_W-1:0].
  - req_rvalid[i] = s_rvalid && idx==i.
  - s_rready = req_rready[idx].
  - rdata/rlast/rresp fan out unregistered.
- idx >= NUM_REQ (non-power-of-2 NUM_REQ), or nonzero s_rid upper bits:
  - s_rready=1 to drain the beat; no req_rvalid asserted; rid_error set until reset.
  - Draining such a beat with rlast still decrements the count.
- No reordering is imposed; interleaving across IDs is passed through as the cache returns it.

Decomposition:
- Shared package holds:
  - typedef for a read request struct {addr, len, id}.
  - constants CACHE_ARSIZE_64B=3'b110 and AXI_BURST_INCR=2'b01.
  - function for round-robin pick from (vector, pointer).
- One sub-module is natural: arbiter_round_robin (NUM_REQ; inputs req vector, enable; outputs one-hot grant, index; owns the pointer).

Test Plan:
- Reset, then cache_setup_signal=1 with all req_arvalid=4'b1111 for 10 cycles -> req_arready stays 0, s_arvalid 0. Drop setup -> first grant to req0, s_arvalid next cycle with s_arid=0.
- All four requesting continuously, s_arready=1 -> s_arid sequence 0,1,2,3,0 and one AR every 2 cycles.
- Only req2 asserted, pointer at 3 -> wrap search grants 2; pointer becomes 3.
- MAX_OUTSTANDING=2, no R returns -> exactly 2 ARs handshake, third requester stalls; one rlast beat returned -> third grant follows.
- s_rid=1, 4-beat burst, req_rready[1] toggled 1,0,1,1,1 -> s_rready mirrors it; req_rvalid=4'b0010 only; count decrements once at rlast.
- NUM_REQ=3, s_rid=3 beat with rlast -> s_rready=1, no req_rvalid, rid_error=1 sticky until areset.
